// File: rtl/jamma_joy_mux_resp.sv
// -----------------------------------------------------------------------------
// jamma_joy_mux_resp
//
// Adapter-side responder for the two-player JAMMA joystick split link.
// Both players' raw active-low switches are synchronised and debounced per
// bit. The host-driven JSELECT (synchronised) picks which debounced vector is
// presented on the registered shared bus JJOY. A watchdog reports whether the
// host is actually toggling JSELECT.
//
// Ports
//   CLK          in   single clock, rising edge
//   RESET        in   synchronous reset, active-high
//   JSELECT      in   host select, async to CLK (0 = P1, 1 = P2)
//   P1_RAW[7:0]  in   player-1 switches, active-low
//                     (0 up, 1 down, 2 left, 3 right, 4 fire1, 5 fire2,
//                      6 spare, 7 start)
//   P2_RAW[7:0]  in   player-2 switches, same bit map
//   JJOY[7:0]    out  registered shared bus to the host, active-low
//   P1_STABLE    out  debounced player-1 vector
//   P2_STABLE    out  debounced player-2 vector
//   LINK_ACTIVE  out  JSELECT toggled within the last 2^WD_BITS-1 cycles
// -----------------------------------------------------------------------------
`default_nettype none

module jamma_joy_mux_resp #(
  parameter int DEB_BITS = 16,
  parameter int WD_BITS  = 12
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       JSELECT,
  input  logic [7:0] P1_RAW,
  input  logic [7:0] P2_RAW,
  output logic [7:0] JJOY,
  output logic [7:0] P1_STABLE,
  output logic [7:0] P2_STABLE,
  output logic       LINK_ACTIVE
);

  localparam int NBITS = 16;
  localparam logic [DEB_BITS-1:0] DEB_MAX = '1;
  localparam logic [WD_BITS-1:0]  WD_MAX  = '1;

  // ---------------------------------------------------------------------------
  // Synchronisers. Raw switch lanes are packed as {P2, P1}; the idle
  // (released) level is 1, so they reset high.
  // ---------------------------------------------------------------------------
  logic             sel_meta_q;
  logic             sel_sync_q;
  logic             sel_prev_q;
  logic [NBITS-1:0] raw_meta_q;
  logic [NBITS-1:0] raw_sync_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sel_meta_q <= 1'b0;
      sel_sync_q <= 1'b0;
      sel_prev_q <= 1'b0;
      raw_meta_q <= '1;
      raw_sync_q <= '1;
    end else begin
      sel_meta_q <= JSELECT;
      sel_sync_q <= sel_meta_q;
      sel_prev_q <= sel_sync_q;
      raw_meta_q <= {P2_RAW, P1_RAW};
      raw_sync_q <= raw_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bit debounce. Each lane counts consecutive cycles where the synced
  // value disagrees with the accepted value. Agreement at any point, including
  // the cycle the counter sits at max, clears the count; the counter therefore
  // never needs to wrap.
  // ---------------------------------------------------------------------------
  logic [DEB_BITS-1:0] deb_cnt_q [NBITS];
  logic [DEB_BITS-1:0] deb_cnt_d [NBITS];
  logic [NBITS-1:0]    stable_q;
  logic [NBITS-1:0]    stable_d;

  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < NBITS; i++) begin
      if (raw_sync_q[i] == stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_MAX) begin
        stable_d[i]  = raw_sync_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stable_q <= '1;
      for (int i = 0; i < NBITS; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NBITS; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mux. Both inputs of the mux are already registered, so a select
  // edge coinciding with a stable-vector update can only ever present one
  // whole player's registered vector.
  // ---------------------------------------------------------------------------
  logic [7:0] jjoy_q;
  logic [7:0] jjoy_d;

  always_comb begin
    jjoy_d = sel_sync_q ? stable_q[15:8] : stable_q[7:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      jjoy_q <= 8'hFF;
    end else begin
      jjoy_q <= jjoy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Link-activity watchdog. Resets to max so a host that never toggles
  // JSELECT (splitter disabled) reads as inactive from the start.
  // ---------------------------------------------------------------------------
  logic               sel_edge;
  logic [WD_BITS-1:0] wd_cnt_q;
  logic [WD_BITS-1:0] wd_cnt_d;
  logic               link_q;
  logic               link_d;

  always_comb begin
    sel_edge = sel_sync_q ^ sel_prev_q;
    wd_cnt_d = wd_cnt_q;
    if (sel_edge) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_MAX) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    link_d = (wd_cnt_q != WD_MAX);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wd_cnt_q <= WD_MAX;
      link_q   <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      link_q   <= link_d;
    end
  end

  assign JJOY        = jjoy_q;
  assign P1_STABLE   = stable_q[7:0];
  assign P2_STABLE   = stable_q[15:8];
  assign LINK_ACTIVE = link_q;

endmodule

`default_nettype wire

// File: tb/tb_jamma_joy_mux_resp.sv
// -----------------------------------------------------------------------------
// tb_jamma_joy_mux_resp
//
// Scoreboard bench: each stimulus step pushes its expected outputs, tagged
// with the cycle (count of rising edges) at which they must be visible. The
// checker samples on the falling edge and compares every entry that is due.
// DEB_BITS = WD_BITS = 4. Latencies counted in rising edges from an input
// change: select -> JJOY 3, raw -> stable 2+15+1 = 18, raw -> JJOY 19.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_jamma_joy_mux_resp;

  localparam int SIG_JJOY = 0;
  localparam int SIG_P1   = 1;
  localparam int SIG_P2   = 2;
  localparam int SIG_LINK = 3;

  localparam int SEL_LAT = 3;
  localparam int DEB_LAT = 2 + 15 + 1;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       JSELECT;
  logic [7:0] P1_RAW;
  logic [7:0] P2_RAW;
  logic [7:0] JJOY;
  logic [7:0] P1_STABLE;
  logic [7:0] P2_STABLE;
  logic       LINK_ACTIVE;

  jamma_joy_mux_resp #(
    .DEB_BITS(4),
    .WD_BITS (4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .JSELECT    (JSELECT),
    .P1_RAW     (P1_RAW),
    .P2_RAW     (P2_RAW),
    .JJOY       (JJOY),
    .P1_STABLE  (P1_STABLE),
    .P2_STABLE  (P2_STABLE),
    .LINK_ACTIVE(LINK_ACTIVE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int         due;
    int         sig;
    logic [7:0] exp;
    string      tag;
  } sb_t;

  sb_t sb[$];

  task automatic expect_at(input int sig, input int dly, input logic [7:0] val, input string tag);
    sb_t e;
    e.due = cyc + dly;
    e.sig = sig;
    e.exp = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] observe(input int sig);
    case (sig)
      SIG_JJOY: return JJOY;
      SIG_P1:   return P1_STABLE;
      SIG_P2:   return P2_STABLE;
      default:  return {7'b0, LINK_ACTIVE};
    endcase
  endfunction

  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check_eq(sb[i].tag, {24'b0, observe(sb[i].sig)}, {24'b0, sb[i].exp});
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL tb_timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    RESET   = 1'b1;
    JSELECT = 1'b0;
    P1_RAW  = 8'h5A;
    P2_RAW  = 8'hA5;

    // Reset with arbitrary raw inputs; stable values hold until debounce completes.
    expect_at(SIG_JJOY, 2, 8'hFF, "rst_jjoy");
    expect_at(SIG_P1,   2, 8'hFF, "rst_p1");
    expect_at(SIG_P2,   2, 8'hFF, "rst_p2");
    expect_at(SIG_LINK, 2, 8'h00, "rst_link");
    tick(2);
    RESET = 1'b0;
    expect_at(SIG_P1,   DEB_LAT - 1, 8'hFF, "rst_hold_p1");
    expect_at(SIG_JJOY, DEB_LAT,     8'hFF, "rst_hold_jjoy");
    expect_at(SIG_P1,   DEB_LAT,     8'h5A, "first_deb_p1");
    expect_at(SIG_P2,   DEB_LAT,     8'hA5, "first_deb_p2");
    expect_at(SIG_JJOY, DEB_LAT + 1, 8'h5A, "first_deb_jjoy");
    expect_at(SIG_LINK, DEB_LAT + 1, 8'h00, "sel0_link_a");
    tick(22);
    P1_RAW = 8'hFF;
    P2_RAW = 8'hFF;
    expect_at(SIG_P1,   DEB_LAT,     8'hFF, "release_p1");
    expect_at(SIG_P2,   DEB_LAT,     8'hFF, "release_p2");
    expect_at(SIG_JJOY, DEB_LAT + 1, 8'hFF, "release_jjoy");
    tick(22);

    // Fire1 press on P1, select held at P1.
    P1_RAW = 8'hEF;
    expect_at(SIG_P1,   DEB_LAT - 1, 8'hFF, "deb_early_p1");
    expect_at(SIG_P1,   DEB_LAT,     8'hEF, "deb_p1");
    expect_at(SIG_JJOY, DEB_LAT,     8'hFF, "deb_early_jjoy");
    expect_at(SIG_JJOY, DEB_LAT + 1, 8'hEF, "deb_jjoy");
    expect_at(SIG_LINK, DEB_LAT + 1, 8'h00, "sel0_link_b");
    tick(22);

    // 10-cycle release pulse on bit 4 must be rejected.
    expect_at(SIG_P1, 5,  8'hEF, "pulse_p1_a");
    expect_at(SIG_P1, 15, 8'hEF, "pulse_p1_b");
    expect_at(SIG_P1, 25, 8'hEF, "pulse_p1_c");
    P1_RAW = 8'hFF;
    tick(10);
    P1_RAW = 8'hEF;
    tick(20);
    P1_RAW = 8'hFF;
    expect_at(SIG_P1, DEB_LAT, 8'hFF, "pulse_restore_p1");
    tick(22);

    // Bounce back exactly when the counter reaches max: 15 synced low cycles.
    P1_RAW = 8'hFE;
    expect_at(SIG_P1,   DEB_LAT,     8'hFF, "bounce_p1_a");
    expect_at(SIG_P1,   DEB_LAT + 2, 8'hFF, "bounce_p1_b");
    expect_at(SIG_JJOY, DEB_LAT + 3, 8'hFF, "bounce_jjoy");
    tick(15);
    P1_RAW = 8'hFF;
    tick(10);
    // Counter was cleared: a fresh press needs the full debounce again.
    P1_RAW = 8'hFE;
    expect_at(SIG_P1,   DEB_LAT - 1, 8'hFF, "rearm_early_p1");
    expect_at(SIG_P1,   DEB_LAT,     8'hFE, "rearm_p1");
    expect_at(SIG_JJOY, DEB_LAT + 1, 8'hFE, "rearm_jjoy");
    tick(22);

    // Mux: P1 = 7F, P2 = FE, toggle select every 4 cycles.
    P1_RAW = 8'h7F;
    P2_RAW = 8'hFE;
    expect_at(SIG_P1,   DEB_LAT,     8'h7F, "mux_setup_p1");
    expect_at(SIG_P2,   DEB_LAT,     8'hFE, "mux_setup_p2");
    expect_at(SIG_JJOY, DEB_LAT + 1, 8'h7F, "mux_setup_jjoy");
    tick(22);
    for (int i = 0; i < 4; i++) begin
      JSELECT = ~JSELECT;
      expect_at(SIG_JJOY, SEL_LAT - 1, JSELECT ? 8'h7F : 8'hFE, "mux_old");
      expect_at(SIG_JJOY, SEL_LAT,     JSELECT ? 8'hFE : 8'h7F, "mux_new");
      tick(4);
    end
    tick(25);

    // Watchdog: three toggles then hold. Synced edge 2 cycles after the raw
    // change, counter loads 0 one cycle later, LINK_ACTIVE registered after.
    // Idle: counter climbs 0..15 over 15 cycles, LINK_ACTIVE drops one later.
    expect_at(SIG_LINK, 1, 8'h00, "wd_idle");
    JSELECT = 1'b1;
    expect_at(SIG_LINK, 3, 8'h00, "wd_rise_early");
    expect_at(SIG_LINK, 4, 8'h01, "wd_rise");
    tick(4);
    JSELECT = 1'b0;
    expect_at(SIG_LINK, 2, 8'h01, "wd_hold");
    tick(4);
    JSELECT = 1'b1;
    expect_at(SIG_JJOY, SEL_LAT, 8'hFE, "wd_jjoy");
    expect_at(SIG_LINK, 18, 8'h01, "wd_fall_early");
    expect_at(SIG_LINK, 19, 8'h00, "wd_fall");
    tick(25);

    // Reset with JSELECT held at 0 afterwards: link never rises, bus serves P1.
    RESET   = 1'b1;
    JSELECT = 1'b0;
    expect_at(SIG_JJOY, 1, 8'hFF, "rst2_jjoy");
    expect_at(SIG_P2,   1, 8'hFF, "rst2_p2");
    tick(1);
    RESET = 1'b0;
    expect_at(SIG_LINK, 5,           8'h00, "sel0_link_c");
    expect_at(SIG_P1,   DEB_LAT,     8'h7F, "sel0_p1");
    expect_at(SIG_JJOY, DEB_LAT + 1, 8'h7F, "sel0_jjoy_a");
    expect_at(SIG_LINK, 30,          8'h00, "sel0_link_d");
    tick(22);
    P1_RAW = 8'hF7;
    expect_at(SIG_P1,   DEB_LAT,     8'hF7, "sel0_p1_b");
    expect_at(SIG_JJOY, DEB_LAT + 1, 8'hF7, "sel0_jjoy_b");
    expect_at(SIG_LINK, DEB_LAT + 1, 8'h00, "sel0_link_e");
    tick(22);

    // Reset mid-debounce (counter = 10) with JSELECT = 1.
    JSELECT = 1'b1;
    expect_at(SIG_JJOY, SEL_LAT, 8'hFE, "mid_pre_jjoy");
    expect_at(SIG_LINK, 6,       8'h01, "mid_pre_link");
    tick(8);
    P2_RAW = 8'hFC;
    expect_at(SIG_P2, 10, 8'hFE, "mid_pre_p2");
    tick(12);
    RESET = 1'b1;
    expect_at(SIG_JJOY, 1, 8'hFF, "mid_rst_jjoy");
    expect_at(SIG_P1,   1, 8'hFF, "mid_rst_p1");
    expect_at(SIG_P2,   1, 8'hFF, "mid_rst_p2");
    expect_at(SIG_LINK, 1, 8'h00, "mid_rst_link");
    tick(1);
    RESET = 1'b0;
    expect_at(SIG_LINK, 3,           8'h00, "mid_link_early");
    expect_at(SIG_LINK, 4,           8'h01, "mid_link");
    expect_at(SIG_P2,   DEB_LAT - 1, 8'hFF, "mid_early_p2");
    expect_at(SIG_P2,   DEB_LAT,     8'hFC, "mid_p2");
    expect_at(SIG_P1,   DEB_LAT,     8'hF7, "mid_p1");
    expect_at(SIG_JJOY, DEB_LAT,     8'hFF, "mid_early_jjoy");
    expect_at(SIG_JJOY, DEB_LAT + 1, 8'hFC, "mid_jjoy");
    tick(25);

    for (int i = 0; i < 100 && sb.size() != 0; i++) tick(1);
    check_eq("sb_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
